processor_datapath: RTL

PROCESSOR_DATAPATH -- requirements
Module: processor_datapath

---
 rtl/processor_datapath.sv | 86 ++++++++
 1 files changed

// File: rtl/processor_datapath.sv
// Datapath for a small multi-cycle processor: shared bus, four-entry register
// file, A/G operand registers, ALU, instruction register and timestep counter.
module processor_datapath (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data,
    input  logic [9:0] IMM,
    input  logic [1:0] Rin,
    input  logic [1:0] Rout,
    input  logic       ENW,
    input  logic       ENR,
    input  logic       Ain,
    input  logic       Gin,
    input  logic       Gout,
    input  logic       Ext,
    input  logic       IRin,
    input  logic       Clr,
    input  logic [3:0] ALUcont,
    output logic [9:0] IR,
    output logic [1:0] timestep,
    output logic [9:0] bus,
    output logic       done
);

    logic [9:0] rf [4];
    logic [9:0] a_reg;
    logic [9:0] g_reg;
    logic [9:0] alu_y;
    logic [3:0] shamt;

    assign shamt = g_reg[3:0];

    // Shifts of 10..15 fall out of the 10-bit operators naturally:
    // zero fill for << and >>, sign fill for >>>.
    always_comb begin
        alu_y = '0;
        case (ALUcont)
            4'b0010: alu_y = a_reg + g_reg;
            4'b0011: alu_y = a_reg - g_reg;
            4'b0100: alu_y = a_reg & g_reg;
            4'b0101: alu_y = a_reg | g_reg;
            4'b0110: alu_y = a_reg ^ g_reg;
            4'b0111: alu_y = ~a_reg;
            4'b1000: alu_y = a_reg << shamt;
            4'b1001: alu_y = a_reg >> shamt;
            4'b1010: alu_y = $signed(a_reg) >>> shamt;
            4'b1011: alu_y = {9'b0, ($signed(a_reg) < $signed(g_reg))};
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        if (Ext)
            bus = data;
        else if (Gout)
            bus = alu_y;
        else if (ENR)
            bus = rf[Rout];
        else
            bus = IMM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                rf[i] <= '0;
            a_reg    <= '0;
            g_reg    <= '0;
            IR       <= '0;
            timestep <= 2'b00;
            done     <= 1'b0;
        end else begin
            if (ENW)
                rf[Rin] <= bus;
            if (Ain)
                a_reg <= bus;
            if (Gin)
                g_reg <= bus;
            if (IRin)
                IR <= bus;
            timestep <= Clr ? 2'b00 : timestep + 2'd1;
            done     <= Clr;
        end
    end

endmodule
